ai_layer_sequencer: RTL
=======================

AI_LAYER_SEQUENCER -- requirements
Module: ai_layer_sequencer

Interface
REQ-001 Parameter IN_DIM, default 32: activation beats fed per layer; also the buffer depth.
REQ-002 Parameter N_FEAT, default 4: external input features consumed per inference.
REQ-003 Parameter AW, default 8: activation width.
REQ-004 Parameter ACCW, default 18: MMU result width.
REQ-005 Parameter SHIFT, default 4: requantization right-shift.
REQ-006 Port clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-007 Port reset  in  1  asynchronous active-high reset.
REQ-008 Port inf_start  in  1  begin one 4-layer inference; honoured in IDLE only.
REQ-009 Port feat_valid  in  1  external feature beat valid.
REQ-010 Port feat_in  in  AW  signed external feature.
REQ-011 Port feat_ready  out  1  high only in LOAD.
REQ-012 Port mmu_start  out  1  one-cycle start pulse to the MMU.
REQ-013 Port mmu_layer_sel  out  2  current layer, 0..3, held stable from the start pulse through mmu_done.
REQ-014 Port mmu_act_valid  out  1  activation beat valid.
REQ-015 Port mmu_act_in  out  AW  activation value.
REQ-016 Port mmu_res_valid  in  1  MMU result beat valid.
REQ-017 Port mmu_res_out  in  ACCW  MMU result, one neuron per beat, index 0 first.
REQ-018 Port mmu_done  in  1  MMU last-result pulse.
REQ-019 Port out_valid  out  1  one-cycle final-result strobe.
REQ-020 Port out_data  out  ACCW  signed final inference result.
REQ-021 Port busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, LOAD, START, FEED, COLLECT, FINISH.
REQ-023 IDLE transitions to LOAD on inf_start; layer is set to 0 and buffer entries N_FEAT..IN_DIM-1 are zeroed.
REQ-024 LOAD:
- feat_ready=1.
- Each feat_valid&feat_ready beat writes buf[fcnt], then fcnt increments.
- After the N_FEAT-th beat, transition to START.
REQ-025 START: mmu_start=1 for exactly one cycle; next state FEED with rcnt=0.
REQ-026 FEED:
- Drive mmu_act_valid=1 and mmu_act_in=buf[rcnt] for IN_DIM consecutive cycles, starting the cycle after the start pulse; no gaps.
- After beat IN_DIM-1, transition to COLLECT with wcnt=0.
REQ-027 COLLECT, layers 0-2:
- Each mmu_res_valid beat with wcnt<IN_DIM writes buf[wcnt]=requant(mmu_res_out), then wcnt increments.
- Beats with wcnt>=IN_DIM are ignored.
REQ-028 requant(x):
- 0 if x[ACCW-1]=1.
- Otherwise min(x>>SHIFT, 2^(AW-1)-1), a logical shift.
- Result is always 0..127.
REQ-029 COLLECT, layer 3: capture the wcnt=0 beat, unmodified, into out_data; discard all other beats.
REQ-030 On mmu_done in COLLECT:
- If layer<3: increment layer and go to START.
- If layer=3: go to FINISH.
REQ-031 FINISH: out_valid=1 for one cycle; next state IDLE; out_data holds until the next capture.
REQ-032 Buffer read/write hazard: none. The buffer is single-ported logically; all FEED reads complete before any COLLECT write.
REQ-033 Simultaneous events:
- inf_start while busy=1 is ignored.
- feat_valid outside LOAD is ignored.
- mmu_res_valid outside COLLECT is ignored.
REQ-034 If mmu_done arrives with wcnt<IN_DIM, unwritten entries keep their prior contents and the transition still occurs.
REQ-035 Latency, given feat_valid continuously high: inf_start to out_valid = 1 + N_FEAT + 4*(1+IN_DIM+MMU result latency) + 1 cycles.

Reset
REQ-036 Reset (asynchronous, mid-operation included) forces:
- state=IDLE; layer, fcnt, rcnt, wcnt = 0.
- All outputs 0: feat_ready, mmu_start, mmu_layer_sel, mmu_act_valid, mmu_act_in, out_valid, out_data, busy.
REQ-037 Buffer contents need no reset; entries 0..N_FEAT-1 are overwritten in LOAD before any read.
REQ-038 The first inf_start after reset release starts a clean inference.

Structure
REQ-039 Package ai_pkg holds:
- the sequencer state enum;
- IN_DIM/AW/ACCW defaults;
- layer index constants LAYER_D0..LAYER_D3.
REQ-040 Requantization lives in one combinational sub-module, ai_requant, parameterized by AW, ACCW, SHIFT.
REQ-041 The buffer is an IN_DIM x AW register array inside the sequencer.

Verification
REQ-042 Scenario, feature load: reset, inf_start, features 1,2,3,4 -> layer 0 feeds 1,2,3,4 followed by 28 zeros; mmu_start precedes the first act beat by 1 cycle.
REQ-043 Scenario, requant clamp: MMU model returns 0x3FFFF, 0x00800, 0x00035, 0x20000 -> buffer 0, 127, 3, 0; layer-1 feed shows those values.
REQ-044 Scenario, full inference: 4 layers; layer-3 beat 0 = -5 (0x3FFFB) -> out_valid one cycle after layer-3 mmu_done, out_data=0x3FFFB; busy falls with out_valid.
REQ-045 Scenario, ignored inputs: inf_start pulsed during FEED -> no effect; 33 res beats in one layer -> 33rd ignored.
REQ-046 Scenario, reset mid-operation: reset during layer-2 FEED -> all outputs 0 next cycle; new inference then completes normally.
REQ-047 Scenario, feature stall: feat_valid low for 5 cycles between features -> mmu_start waits until the 4th feature is accepted.

Source files
------------

// File: rtl/ai_pkg.sv
// Shared types and constants for the four-layer inference sequencer.
// Holds the sequencer state encoding, width defaults and layer indices.
package ai_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_FEED,
        ST_COLLECT,
        ST_FINISH
    } seq_state_e;

    localparam int IN_DIM_DEF = 32;
    localparam int AW_DEF     = 8;
    localparam int ACCW_DEF   = 18;

    localparam logic [1:0] LAYER_D0 = 2'd0;
    localparam logic [1:0] LAYER_D1 = 2'd1;
    localparam logic [1:0] LAYER_D2 = 2'd2;
    localparam logic [1:0] LAYER_D3 = 2'd3;

endpackage

// File: rtl/ai_requant.sv
// Requantizes an MMU accumulator to a non-negative activation:
// negatives become 0, positives are shifted right and clamped to the signed max.
module ai_requant #(
    parameter int AW    = 8,
    parameter int ACCW  = 18,
    parameter int SHIFT = 4
) (
    input  logic [ACCW-1:0] x_i,
    output logic [AW-1:0]   y_o
);
    localparam logic [ACCW-1:0] MAX_VAL = ACCW'((1 << (AW - 1)) - 1);

    logic [ACCW-1:0] shifted;
    assign shifted = x_i >> SHIFT;

    always_comb begin
        y_o = shifted[AW-1:0];
        if (x_i[ACCW-1]) begin
            y_o = '0;
        end else if (shifted > MAX_VAL) begin
            y_o = MAX_VAL[AW-1:0];
        end
    end
endmodule

// File: rtl/ai_layer_sequencer.sv
// Drives four MMU layers back to back, ping-ponging activations through one buffer
// and returning the first neuron of the last layer as the inference result.
module ai_layer_sequencer
    import ai_pkg::*;
#(
    parameter int IN_DIM = IN_DIM_DEF,
    parameter int N_FEAT = 4,
    parameter int AW     = AW_DEF,
    parameter int ACCW   = ACCW_DEF,
    parameter int SHIFT  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inf_start,
    input  logic                   feat_valid,
    input  logic signed [AW-1:0]   feat_in,
    output logic                   feat_ready,
    output logic                   mmu_start,
    output logic [1:0]             mmu_layer_sel,
    output logic                   mmu_act_valid,
    output logic [AW-1:0]          mmu_act_in,
    input  logic                   mmu_res_valid,
    input  logic signed [ACCW-1:0] mmu_res_out,
    input  logic                   mmu_done,
    output logic                   out_valid,
    output logic signed [ACCW-1:0] out_data,
    output logic                   busy
);
    localparam int RW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int CW = $clog2(IN_DIM + 1);

    seq_state_e             state_q, state_d;
    logic [1:0]             layer_q, layer_d;
    logic [RW-1:0]          fcnt_q, fcnt_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic [CW-1:0]          wcnt_q, wcnt_d;
    logic signed [ACCW-1:0] out_data_q, out_data_d;

    logic [AW-1:0]     buf_q [IN_DIM];
    logic [IN_DIM-1:0] wr_en;
    logic [AW-1:0]     wr_data;
    logic [AW-1:0]     rq_val;
    logic              clear_tail;
    logic              feat_fire;
    logic              res_write;

    ai_requant #(
        .AW    (AW),
        .ACCW  (ACCW),
        .SHIFT (SHIFT)
    ) u_requant (
        .x_i (mmu_res_out),
        .y_o (rq_val)
    );

    // wcnt saturates at IN_DIM, so any surplus result beats never reach the buffer
    assign clear_tail = (state_q == ST_IDLE) && inf_start;
    assign feat_fire  = (state_q == ST_LOAD) && feat_valid;
    assign res_write  = (state_q == ST_COLLECT) && mmu_res_valid
                        && (wcnt_q < CW'(IN_DIM)) && (layer_q != LAYER_D3);

    always_comb begin
        wr_data = '0;
        if (state_q == ST_LOAD) begin
            wr_data = feat_in;
        end else if (state_q == ST_COLLECT) begin
            wr_data = rq_val;
        end
    end

    generate
        for (genvar gi = 0; gi < IN_DIM; gi++) begin : g_wr_en
            assign wr_en[gi] = (clear_tail && (gi >= N_FEAT))
                               || (feat_fire && (fcnt_q == RW'(gi)))
                               || (res_write && (wcnt_q == CW'(gi)));
        end
    endgenerate

    // Contents need no reset: every entry is loaded or cleared before its first read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_DIM; i++) begin
            if (wr_en[i]) begin
                buf_q[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            layer_q    <= LAYER_D0;
            fcnt_q     <= '0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            fcnt_q     <= fcnt_d;
            rcnt_q     <= rcnt_d;
            wcnt_q     <= wcnt_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        layer_d       = layer_q;
        fcnt_d        = fcnt_q;
        rcnt_d        = rcnt_q;
        wcnt_d        = wcnt_q;
        out_data_d    = out_data_q;
        feat_ready    = 1'b0;
        mmu_start     = 1'b0;
        mmu_act_valid = 1'b0;
        mmu_act_in    = '0;
        out_valid     = 1'b0;
        busy          = (state_q != ST_IDLE);
        mmu_layer_sel = layer_q;
        out_data      = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (inf_start) begin
                    state_d = ST_LOAD;
                    layer_d = LAYER_D0;
                    fcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                feat_ready = 1'b1;
                if (feat_valid) begin
                    fcnt_d = fcnt_q + 1'b1;
                    if (fcnt_q == RW'(N_FEAT - 1)) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                mmu_start = 1'b1;
                rcnt_d    = '0;
                state_d   = ST_FEED;
            end
            ST_FEED: begin
                mmu_act_valid = 1'b1;
                mmu_act_in    = buf_q[rcnt_q];
                rcnt_d        = rcnt_q + 1'b1;
                if (rcnt_q == RW'(IN_DIM - 1)) begin
                    rcnt_d  = '0;
                    wcnt_d  = '0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (mmu_res_valid && (wcnt_q < CW'(IN_DIM))) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if ((layer_q == LAYER_D3) && (wcnt_q == '0)) begin
                        out_data_d = mmu_res_out;
                    end
                end
                // A short result burst still advances; unwritten entries keep old data.
                if (mmu_done) begin
                    if (layer_q == LAYER_D3) begin
                        state_d = ST_FINISH;
                    end else begin
                        layer_d = layer_q + 1'b1;
                        state_d = ST_START;
                    end
                end
            end
            ST_FINISH: begin
                out_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule
